pal_macrocell_array: RTL and testbench

- Parametrised successor PAL fabric with a programmable AND plane, a programmable OR plane and one macrocell per output.
- Each macrocell selects combinational or registered output and can invert it. Registered outputs feed back into the AND plane.
- Configuration shifts serially into a shadow chain on the fabric clock. An explicit commit copies it atomically to the active plane, so the fabric never runs a half-loaded config.
- Sits behind the tile top wrapper: pins drive in_vars, the cfg_* strobes and out_vals.

---
 rtl/pal_macrocell_array_if.sv | 27 ++
 rtl/pal_macrocell_array.sv | 185 ++++++++++++++++++
 tb/tb_pal_macrocell_array.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pal_macrocell_array_if.sv
// Fabric and configuration signal bundle between the tile wrapper and the PAL array.
// The wrapper drives the master side; the array sits on the slave side.
interface pal_macrocell_array_if #(
  parameter int N = 8,
  parameter int M = 8
);
  logic         fabric_en;
  logic         cfg_start;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_commit;
  logic [N-1:0] in_vars;
  logic [M-1:0] out_vals;
  logic         cfg_ready;
  logic         cfg_active;
  logic         cfg_err;

  modport master (
    output fabric_en, cfg_start, cfg_valid, cfg_bit, cfg_commit, in_vars,
    input  out_vals, cfg_ready, cfg_active, cfg_err
  );

  modport slave (
    input  fabric_en, cfg_start, cfg_valid, cfg_bit, cfg_commit, in_vars,
    output out_vals, cfg_ready, cfg_active, cfg_err
  );
endinterface

// File: rtl/pal_macrocell_array.sv
// Parametrised PAL fabric: programmable AND/OR planes plus one macrocell per output.
// Config shifts serially into a shadow chain and is committed atomically to the active plane.
module pal_macrocell_array #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int P = 11
) (
  input  logic                  clk,
  input  logic                  res,
  pal_macrocell_array_if.slave  io_bus
);
  localparam int L       = N + M;
  localparam int TW      = 2 * L;
  localparam int A       = P * TW;
  localparam int B       = A + M * P;
  localparam int CFG_LEN = B + 2 * M;
  localparam int CW      = $clog2(CFG_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CFG_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CFG_LEN-1:0] r_shadow;
  logic [CFG_LEN-1:0] r_active;
  logic [CW-1:0]      r_cnt;
  logic [M-1:0]       r_q;
  logic               r_ready;
  logic               r_live;
  logic               r_err;

  logic               w_shift;
  logic               w_commit;
  logic               w_err_set;
  logic [L-1:0]       w_lit;
  logic [P-1:0]       w_term;
  logic [M-1:0]       w_sum;
  logic [M-1:0]       w_mc_out;

  // Config FSM state register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; cfg_start overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    if (io_bus.cfg_start) begin
      w_state_nxt = ST_SHIFT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_SHIFT: begin
          if (io_bus.cfg_valid && (r_cnt == CNT_LAST)) begin
            w_state_nxt = ST_READY;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end
        ST_READY: begin
          if (io_bus.cfg_commit && !io_bus.cfg_valid) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_READY;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM action decode: shift, commit and protocol-error strobes.
  always_comb begin
    w_shift   = 1'b0;
    w_commit  = 1'b0;
    w_err_set = 1'b0;
    if (!io_bus.cfg_start) begin
      case (r_state)
        ST_IDLE: begin
          w_err_set = io_bus.cfg_commit;
        end
        ST_SHIFT: begin
          w_shift   = io_bus.cfg_valid;
          w_err_set = io_bus.cfg_commit;
        end
        ST_READY: begin
          // Commit together with an overflowing bit is rejected as a whole.
          w_commit  = io_bus.cfg_commit & ~io_bus.cfg_valid;
          w_err_set = io_bus.cfg_valid;
        end
        default: begin
          w_err_set = 1'b1;
        end
      endcase
    end else begin
      w_shift   = 1'b0;
      w_commit  = 1'b0;
      w_err_set = 1'b0;
    end
  end

  // Shadow chain and bit counter.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_shadow <= {CFG_LEN{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (io_bus.cfg_start) begin
      r_cnt    <= {CW{1'b0}};
    end else if (w_shift) begin
      r_shadow <= {r_shadow[CFG_LEN-2:0], io_bus.cfg_bit};
      r_cnt    <= r_cnt + CNT_ONE;
    end
  end

  // Status flags: ready, sticky error, live config.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == ST_READY);
      if (io_bus.cfg_start) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_commit) begin
        r_live <= 1'b1;
      end
    end
  end

  // Active plane and macrocell flops; a commit restarts the flops from zero.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_active <= {CFG_LEN{1'b0}};
      r_q      <= {M{1'b0}};
    end else if (w_commit) begin
      r_active <= r_shadow;
      r_q      <= {M{1'b0}};
    end else if (io_bus.fabric_en && r_live) begin
      r_q      <= w_sum;
    end
  end

  // Feedback literals come only from the flops, so no combinational loop can form.
  assign w_lit = {r_q, io_bus.in_vars};

  genvar gt, gi, gm;
  for (gt = 0; gt < P; gt++) begin : g_term
    logic [L-1:0] w_pos;
    logic [L-1:0] w_neg;
    for (gi = 0; gi < L; gi++) begin : g_lit
      assign w_pos[gi] = r_active[gt*TW + 2*gi];
      assign w_neg[gi] = r_active[gt*TW + 2*gi + 1];
    end
    // An empty term reads as 0 rather than the AND identity.
    assign w_term[gt] = (|(w_pos | w_neg)) &
                        (&((~w_pos | w_lit) & (~w_neg | ~w_lit)));
  end

  for (gm = 0; gm < M; gm++) begin : g_mc
    assign w_sum[gm]    = |(r_active[A + gm*P +: P] & w_term);
    assign w_mc_out[gm] = (r_active[B + 2*gm] ? r_q[gm] : w_sum[gm]) ^ r_active[B + 2*gm + 1];
  end

  assign io_bus.out_vals   = r_live ? w_mc_out : {M{1'b0}};
  assign io_bus.cfg_ready  = r_ready;
  assign io_bus.cfg_active = r_live;
  assign io_bus.cfg_err    = r_err;
endmodule

// File: tb/tb_pal_macrocell_array.sv
// Self-checking bench for pal_macrocell_array at N=2, M=2, P=2 (CFG_LEN=24).
// Expected values are queued as stimulus is driven and checked on the falling edge.
module tb_pal_macrocell_array;
  localparam int N = 2;
  localparam int M = 2;
  localparam int P = 2;
  localparam int CFG_LEN = 24;

  localparam int K_OUT = 0;
  localparam int K_RDY = 1;
  localparam int K_ACT = 2;
  localparam int K_ERR = 3;

  localparam int G_XOR = 0;
  localparam int G_AND = 1;
  localparam int G_INV = 2;

  localparam logic [CFG_LEN-1:0] PAT_XOR = 24'h030609;
  localparam logic [CFG_LEN-1:0] PAT_AND = 24'h010005;
  localparam logic [CFG_LEN-1:0] PAT_TGL = 24'h440080;
  localparam logic [CFG_LEN-1:0] PAT_INV = 24'hA00000;

  typedef struct packed {
    logic [3:0]   grp;
    logic [N-1:0] in_v;
    logic [M-1:0] exp;
  } vec_t;

  logic  clk;
  logic  res;
  vec_t  vec_tbl [12];
  int    kind_q [$];
  int    exp_q  [$];
  string name_q [$];
  int    n_cmp;
  int    n_bad;

  pal_macrocell_array_if #(.N(N), .M(M)) bus ();

  pal_macrocell_array #(.N(N), .M(M), .P(P)) dut (
    .clk    (clk),
    .res    (res),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: a run that never reaches the summary is a failure.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation wait expired at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Scoreboard: drain every queued expectation on the falling edge.
  always @(negedge clk) begin
    int    k;
    int    e;
    int    a;
    string nm;
    while (kind_q.size() > 0) begin
      k  = kind_q.pop_front();
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (k)
        K_OUT:   a = int'(bus.out_vals);
        K_RDY:   a = int'(bus.cfg_ready);
        K_ACT:   a = int'(bus.cfg_active);
        default: a = int'(bus.cfg_err);
      endcase
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input int val, input string nm);
    kind_q.push_back(kind);
    exp_q.push_back(val);
    name_q.push_back(nm);
  endtask

  task automatic check_now(input int kind, input int val, input string nm);
    int a;
    case (kind)
      K_OUT:   a = int'(bus.out_vals);
      K_RDY:   a = int'(bus.cfg_ready);
      K_ACT:   a = int'(bus.cfg_active);
      default: a = int'(bus.cfg_err);
    endcase
    n_cmp++;
    if (a !== val) begin
      n_bad++;
      $display("FAIL %s (immediate): got %0d expected %0d at %0t", nm, a, val, $time);
    end
  endtask

  // hold_exp >= 0 also checks out_vals on every shift cycle.
  task automatic shift_cfg(input logic [CFG_LEN-1:0] pat, input int hold_exp);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    for (int k = CFG_LEN - 1; k >= 0; k--) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = pat[k];
      tick();
      if (hold_exp >= 0) expect_v(K_OUT, hold_exp, "live_hold");
    end
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    expect_v(K_RDY, 1, "ready_after_shift");
  endtask

  task automatic commit_cfg();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    expect_v(K_ACT, 1, "active_after_commit");
    expect_v(K_RDY, 0, "ready_clr_commit");
  endtask

  task automatic run_group(input int g, input string nm);
    for (int i = 0; i < 12; i++) begin
      if (int'(vec_tbl[i].grp) == g) begin
        bus.in_vars = vec_tbl[i].in_v;
        expect_v(K_OUT, int'(vec_tbl[i].exp), nm);
        tick();
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vec_tbl[0]  = '{4'd0, 2'b00, 2'b00};
    vec_tbl[1]  = '{4'd0, 2'b01, 2'b01};
    vec_tbl[2]  = '{4'd0, 2'b10, 2'b01};
    vec_tbl[3]  = '{4'd0, 2'b11, 2'b00};
    vec_tbl[4]  = '{4'd1, 2'b11, 2'b01};
    vec_tbl[5]  = '{4'd1, 2'b00, 2'b00};
    vec_tbl[6]  = '{4'd1, 2'b01, 2'b00};
    vec_tbl[7]  = '{4'd1, 2'b10, 2'b00};
    vec_tbl[8]  = '{4'd2, 2'b00, 2'b11};
    vec_tbl[9]  = '{4'd2, 2'b01, 2'b11};
    vec_tbl[10] = '{4'd2, 2'b10, 2'b11};
    vec_tbl[11] = '{4'd2, 2'b11, 2'b11};

    res            = 1'b1;
    bus.fabric_en  = 1'b1;
    bus.cfg_start  = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.cfg_bit    = 1'b0;
    bus.cfg_commit = 1'b0;
    bus.in_vars    = 2'b11;
    tick();
    expect_v(K_OUT, 0, "reset_out");
    expect_v(K_RDY, 0, "reset_ready");
    expect_v(K_ACT, 0, "reset_active");
    expect_v(K_ERR, 0, "reset_err");
    tick();
    res = 1'b0;
    tick();

    // Commit with nothing loaded.
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    expect_v(K_ERR, 1, "idle_commit_err");
    expect_v(K_ACT, 0, "idle_commit_inactive");
    tick();

    // Premature commit after 10 bits.
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    expect_v(K_ERR, 0, "start_clears_err");
    for (int i = 0; i < 10; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = 1'b1;
      tick();
    end
    bus.cfg_valid  = 1'b0;
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    expect_v(K_ERR, 1, "early_commit_err");
    expect_v(K_ACT, 0, "early_commit_inactive");
    expect_v(K_RDY, 0, "early_commit_not_ready");
    tick();

    // Full XOR load, then an overflow bit that must not enter the shadow.
    shift_cfg(PAT_XOR, -1);
    expect_v(K_ERR, 0, "err_clear_after_restart");
    bus.cfg_valid = 1'b1;
    bus.cfg_bit   = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    expect_v(K_ERR, 1, "overflow_err");
    expect_v(K_RDY, 1, "overflow_stays_ready");
    commit_cfg();
    expect_v(K_ERR, 1, "err_sticky");
    run_group(G_XOR, "xor_vec");

    // Live reload: XOR keeps running until the AND config is committed.
    bus.in_vars = 2'b01;
    shift_cfg(PAT_AND, 1);
    commit_cfg();
    run_group(G_AND, "and_vec");

    // Toggle flop on macrocell 1.
    shift_cfg(PAT_TGL, -1);
    commit_cfg();
    for (int i = 0; i < 4; i++) begin
      expect_v(K_OUT, (i % 2) * 2, "toggle_run");
      tick();
    end
    tick();
    bus.fabric_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_v(K_OUT, 2, "toggle_hold");
      tick();
    end
    bus.fabric_en = 1'b1;

    // Inverted empty terms.
    shift_cfg(PAT_INV, -1);
    commit_cfg();
    run_group(G_INV, "invert_vec");

    // Asynchronous reset in the middle of a cycle.
    bus.in_vars = 2'b00;
    expect_v(K_OUT, 3, "pre_reset_out");
    tick();
    #2;
    res = 1'b1;
    #1;
    check_now(K_OUT, 0, "async_reset_out");
    check_now(K_ACT, 0, "async_reset_active");
    check_now(K_RDY, 0, "async_reset_ready");
    check_now(K_ERR, 0, "async_reset_err");
    expect_v(K_OUT, 0, "midcycle_reset_out");
    expect_v(K_ACT, 0, "midcycle_reset_active");
    expect_v(K_RDY, 0, "midcycle_reset_ready");
    expect_v(K_ERR, 0, "midcycle_reset_err");
    tick();
    bus.in_vars = 2'b11;
    expect_v(K_OUT, 0, "reset_held_out");
    tick();
    res = 1'b0;
    bus.in_vars = 2'b10;
    expect_v(K_OUT, 0, "post_reset_out");
    expect_v(K_ACT, 0, "post_reset_active");
    tick();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
